// File: rtl/led_sched_pkg.sv
// Shared encodings and pattern helpers for the LED pattern scheduler.
package led_sched_pkg;

    typedef enum logic [1:0] {
        MODE_OFF    = 2'd0,
        MODE_FLOW_L = 2'd1,
        MODE_FLOW_R = 2'd2,
        MODE_BLINK  = 2'd3
    } mode_e;

    typedef enum logic [1:0] {
        S_OFF  = 2'd0,
        S_LOAD = 2'd1,
        S_RUN  = 2'd2
    } state_e;

    localparam logic [3:0] PAT_OFF    = 4'b0000;
    localparam logic [3:0] PAT_FLOW_L = 4'b0001;
    localparam logic [3:0] PAT_FLOW_R = 4'b1000;
    localparam logic [3:0] PAT_BLINK  = 4'b1111;

    // Pattern shown immediately after a mode is (re)loaded.
    function automatic logic [3:0] start_pattern(input mode_e m);
        case (m)
            MODE_FLOW_L: return PAT_FLOW_L;
            MODE_FLOW_R: return PAT_FLOW_R;
            MODE_BLINK:  return PAT_BLINK;
            default:     return PAT_OFF;
        endcase
    endfunction

    // Pattern after one step of the given mode.
    function automatic logic [3:0] step_pattern(input mode_e m, input logic [3:0] cur);
        case (m)
            MODE_FLOW_L: return {cur[2:0], cur[3]};
            MODE_FLOW_R: return {cur[0], cur[3:1]};
            MODE_BLINK:  return ~cur;
            default:     return cur;
        endcase
    endfunction

endpackage

// File: rtl/led_tick_gen.sv
// Step prescaler: counts 0..TICK_CYCLES-1 while enabled and pulses tick on
// the last count. clear forces the count back to 0.
module led_tick_gen #(
    parameter int TICK_CYCLES = 10_000_000
) (
    input  logic clk,
    input  logic rst,
    input  logic clear,
    input  logic enable,
    output logic tick
);

    localparam int             CW   = $clog2(TICK_CYCLES);
    localparam logic [CW-1:0]  LAST = CW'(TICK_CYCLES - 1);

    logic [CW-1:0] count;

    // Prescaler register; holds its value while not enabled.
    always_ff @(posedge clk) begin
        // NOTE: state registers use non-blocking assignments so every flop
        // samples the pre-edge values of the others.
        if (rst || clear) begin
            count <= '0;
        end else if (enable) begin
            count <= (count == LAST) ? '0 : count + CW'(1);
        end
    end

    assign tick = enable && (count == LAST);

endmodule

// File: rtl/led_pattern_sched.sv
// LED pattern scheduler: host command port plus a key that cycles modes,
// driving a 4-bit LED pattern stepped every TICK_CYCLES clocks.
// Optional feature: define LED_SCHED_PAUSE_EN to add a pause input that
// freezes the running pattern and its prescaler.
module led_pattern_sched
    import led_sched_pkg::*;
#(
    parameter int TICK_CYCLES = 10_000_000
) (
    input  logic       sys_clk,
    input  logic       sys_rst,
    input  logic       cmd_valid,
    input  logic [1:0] cmd_mode,
    output logic       cmd_ready,
    input  logic       key_pulse,
`ifdef LED_SCHED_PAUSE_EN
    input  logic       pause,
`endif
    output logic [3:0] led,
    output logic [1:0] mode,
    output logic       tick
);

    state_e     state_q, state_d;
    mode_e      mode_q, mode_d;
    logic [3:0] led_q, led_d;

    logic accept_cmd;
    logic accept_key;
    logic load_req;
    logic paused;
    logic run_en;
    logic step_tick;

`ifdef LED_SCHED_PAUSE_EN
    assign paused = pause;
`else
    assign paused = 1'b0;
`endif

    // The command port wins; a key in the same cycle is dropped.
    assign cmd_ready  = !sys_rst && (state_q != S_LOAD);
    assign accept_cmd = cmd_valid && cmd_ready;
    assign accept_key = key_pulse && cmd_ready && !accept_cmd;
    assign load_req   = accept_cmd || accept_key;

    // Prescaler only runs in S_RUN; it is held at 0 elsewhere, including the
    // S_LOAD cycle that follows an accept.
    assign run_en = (state_q == S_RUN) && !paused && !sys_rst;

    led_tick_gen #(
        .TICK_CYCLES (TICK_CYCLES)
    ) u_tick_gen (
        .clk    (sys_clk),
        .rst    (sys_rst),
        .clear  ((state_q != S_RUN) || load_req),
        .enable (run_en),
        .tick   (step_tick)
    );

    // Next-state, next-mode and next-pattern decode.
    always_comb begin
        // NOTE: every output gets a default first so no path leaves a
        // signal unassigned, which would infer a latch.
        state_d = state_q;
        mode_d  = mode_q;
        led_d   = led_q;

        case (state_q)
            S_LOAD: begin
                led_d   = start_pattern(mode_q);
                state_d = (mode_q == MODE_OFF) ? S_OFF : S_RUN;
            end
            S_RUN: begin
                if (step_tick) begin
                    led_d = step_pattern(mode_q, led_q);
                end
            end
            default: ;
        endcase

        if (accept_cmd) begin
            mode_d  = mode_e'(cmd_mode);
            state_d = S_LOAD;
        end else if (accept_key) begin
            mode_d  = mode_e'(mode_q + 2'd1);
            state_d = S_LOAD;
        end
    end

    // State, mode and LED registers with synchronous reset.
    always_ff @(posedge sys_clk) begin
        if (sys_rst) begin
            state_q <= S_OFF;
            mode_q  <= MODE_OFF;
            led_q   <= PAT_OFF;
        end else begin
            state_q <= state_d;
            mode_q  <= mode_d;
            led_q   <= led_d;
        end
    end

    assign led  = led_q;
    assign mode = mode_q;
    assign tick = step_tick;

endmodule

// File: tb/tb_led_pattern_sched.sv
// Self-checking bench for led_pattern_sched with TICK_CYCLES=4.
// Directed scenarios plus randomized traffic checked against a behavioural model.
module tb_led_pattern_sched;

    localparam int TB_TICK = 4;

    logic       sys_clk = 1'b0;
    logic       sys_rst = 1'b1;
    logic       cmd_valid = 1'b0;
    logic [1:0] cmd_mode = 2'd0;
    logic       cmd_ready;
    logic       key_pulse = 1'b0;
    logic [3:0] led;
    logic [1:0] mode;
    logic       tick;
    logic       pz;

    int n_compared = 0;
    int n_mismatched = 0;

`ifdef LED_SCHED_PAUSE_EN
    logic pause = 1'b0;
    assign pz = pause;
`else
    assign pz = 1'b0;
`endif

    led_pattern_sched #(.TICK_CYCLES(TB_TICK)) dut (
        .sys_clk   (sys_clk),
        .sys_rst   (sys_rst),
        .cmd_valid (cmd_valid),
        .cmd_mode  (cmd_mode),
        .cmd_ready (cmd_ready),
        .key_pulse (key_pulse),
`ifdef LED_SCHED_PAUSE_EN
        .pause     (pause),
`endif
        .led       (led),
        .mode      (mode),
        .tick      (tick)
    );

    always #5 sys_clk = ~sys_clk;

    // Behavioural model: mode number, loading flag, running flag, step count, pattern value.
    int m_mode = 0;
    int m_cnt  = 0;
    int m_led  = 0;
    bit m_load = 1'b0;
    bit m_run  = 1'b0;
    int init_pat[4] = '{0, 1, 8, 15};

    function automatic int next_pat(input int md, input int v);
        case (md)
            1:       return ((v * 2) % 16) + (v / 8);
            2:       return (v / 2) + ((v % 2) * 8);
            3:       return 15 - v;
            default: return v;
        endcase
    endfunction

    always @(posedge sys_clk) begin : model
        bit rdy;
        bit tk;
        if (sys_rst) begin
            m_mode = 0; m_cnt = 0; m_led = 0; m_load = 1'b0; m_run = 1'b0;
        end else begin
            rdy = !m_load;
            tk  = m_run && !pz && (m_cnt == TB_TICK - 1);
            if (m_load) begin
                m_led  = init_pat[m_mode];
                m_cnt  = 0;
                m_run  = (m_mode != 0);
                m_load = 1'b0;
            end else if (m_run) begin
                if (tk) m_led = next_pat(m_mode, m_led);
                if (!pz) m_cnt = (m_cnt + 1) % TB_TICK;
            end
            if (rdy && cmd_valid) begin
                m_mode = int'(cmd_mode); m_load = 1'b1; m_run = 1'b0; m_cnt = 0;
            end else if (rdy && key_pulse) begin
                m_mode = (m_mode + 1) % 4; m_load = 1'b1; m_run = 1'b0; m_cnt = 0;
            end
        end
    end

    task automatic test_reset();
        sys_rst = 1'b1;
        repeat (3) @(negedge sys_clk);
        n_compared++;
        if (led !== 4'b0000) begin n_mismatched++; $display("FAIL reset_led got=%b exp=0000", led); end
        n_compared++;
        if (mode !== 2'd0) begin n_mismatched++; $display("FAIL reset_mode got=%0d exp=0", mode); end
        n_compared++;
        if (tick !== 1'b0) begin n_mismatched++; $display("FAIL reset_tick got=%b exp=0", tick); end
        n_compared++;
        if (cmd_ready !== 1'b0) begin n_mismatched++; $display("FAIL reset_ready got=%b exp=0", cmd_ready); end
        sys_rst = 1'b0;
        @(negedge sys_clk);
        n_compared++;
        if (cmd_ready !== 1'b1) begin n_mismatched++; $display("FAIL release_ready got=%b exp=1", cmd_ready); end
    endtask

    task automatic test_flow_l();
        logic [3:0] exp;
        cmd_valid = 1'b1; cmd_mode = 2'd1;
        @(negedge sys_clk);
        cmd_valid = 1'b0;
        n_compared++;
        if (mode !== 2'd1) begin n_mismatched++; $display("FAIL flowl_mode got=%0d exp=1", mode); end
        n_compared++;
        if (cmd_ready !== 1'b0) begin n_mismatched++; $display("FAIL flowl_load_ready got=%b exp=0", cmd_ready); end
        @(negedge sys_clk);
        exp = 4'b0001;
        for (int s = 0; s < 5; s++) begin
            for (int c = 0; c < 4; c++) begin
                n_compared++;
                if (led !== exp) begin n_mismatched++; $display("FAIL flowl_led s=%0d c=%0d got=%b exp=%b", s, c, led, exp); end
                n_compared++;
                if (tick !== (c == 3)) begin n_mismatched++; $display("FAIL flowl_tick s=%0d c=%0d got=%b exp=%b", s, c, tick, (c == 3)); end
                @(negedge sys_clk);
            end
            exp = {exp[2:0], exp[3]};
        end
    endtask

    task automatic test_cmd_key_priority();
        cmd_valid = 1'b1; cmd_mode = 2'd2; key_pulse = 1'b1;
        @(negedge sys_clk);
        cmd_valid = 1'b0; key_pulse = 1'b0;
        n_compared++;
        if (mode !== 2'd2) begin n_mismatched++; $display("FAIL prio_mode got=%0d exp=2", mode); end
        @(negedge sys_clk);
        n_compared++;
        if (led !== 4'b1000) begin n_mismatched++; $display("FAIL prio_led0 got=%b exp=1000", led); end
        repeat (4) @(negedge sys_clk);
        n_compared++;
        if (led !== 4'b0100) begin n_mismatched++; $display("FAIL prio_led1 got=%b exp=0100", led); end
    endtask

    task automatic test_back_to_back();
        cmd_valid = 1'b1; cmd_mode = 2'd2;
        for (int i = 0; i < 8; i++) begin
            @(negedge sys_clk);
            n_compared++;
            if (cmd_ready !== (i % 2 == 1)) begin n_mismatched++; $display("FAIL b2b_ready i=%0d got=%b exp=%b", i, cmd_ready, (i % 2 == 1)); end
            n_compared++;
            if (mode !== 2'd2) begin n_mismatched++; $display("FAIL b2b_mode i=%0d got=%0d exp=2", i, mode); end
        end
        cmd_valid = 1'b0;
    endtask

    task automatic test_blink_to_off();
        cmd_valid = 1'b1; cmd_mode = 2'd3;
        @(negedge sys_clk);
        cmd_valid = 1'b0;
        @(negedge sys_clk);
        n_compared++;
        if (led !== 4'b1111) begin n_mismatched++; $display("FAIL blink_led got=%b exp=1111", led); end
        key_pulse = 1'b1;
        @(negedge sys_clk);
        key_pulse = 1'b0;
        n_compared++;
        if (mode !== 2'd0) begin n_mismatched++; $display("FAIL off_mode got=%0d exp=0", mode); end
        for (int i = 0; i < 10; i++) begin
            @(negedge sys_clk);
            n_compared++;
            if (led !== 4'b0000) begin n_mismatched++; $display("FAIL off_led i=%0d got=%b exp=0000", i, led); end
            n_compared++;
            if (tick !== 1'b0) begin n_mismatched++; $display("FAIL off_tick i=%0d got=%b exp=0", i, tick); end
        end
        n_compared++;
        if (cmd_ready !== 1'b1) begin n_mismatched++; $display("FAIL off_ready got=%b exp=1", cmd_ready); end
        key_pulse = 1'b1;
        @(negedge sys_clk);
        key_pulse = 1'b0;
        n_compared++;
        if (mode !== 2'd1) begin n_mismatched++; $display("FAIL key2_mode got=%0d exp=1", mode); end
        @(negedge sys_clk);
        n_compared++;
        if (led !== 4'b0001) begin n_mismatched++; $display("FAIL key2_led got=%b exp=0001", led); end
    endtask

    task automatic test_reset_in_load();
        cmd_valid = 1'b1; cmd_mode = 2'd2;
        @(negedge sys_clk);
        // Now in the load cycle; reset with a different command pending.
        sys_rst = 1'b1; cmd_mode = 2'd3;
        for (int i = 0; i < 3; i++) begin
            @(negedge sys_clk);
            n_compared++;
            if (led !== 4'b0000) begin n_mismatched++; $display("FAIL rstload_led i=%0d got=%b exp=0000", i, led); end
            n_compared++;
            if (mode !== 2'd0) begin n_mismatched++; $display("FAIL rstload_mode i=%0d got=%0d exp=0", i, mode); end
            n_compared++;
            if (cmd_ready !== 1'b0) begin n_mismatched++; $display("FAIL rstload_ready i=%0d got=%b exp=0", i, cmd_ready); end
        end
        sys_rst = 1'b0; cmd_valid = 1'b0;
        @(negedge sys_clk);
        n_compared++;
        if (cmd_ready !== 1'b1) begin n_mismatched++; $display("FAIL rstload_release got=%b exp=1", cmd_ready); end
        n_compared++;
        if (led !== 4'b0000) begin n_mismatched++; $display("FAIL rstload_after_led got=%b exp=0000", led); end
    endtask

`ifdef LED_SCHED_PAUSE_EN
    task automatic test_pause();
        bit found;
        cmd_valid = 1'b1; cmd_mode = 2'd1;
        @(negedge sys_clk);
        cmd_valid = 1'b0;
        found = 1'b0;
        for (int i = 0; i < 20 && !found; i++) begin
            @(negedge sys_clk);
            if (led === 4'b0100) found = 1'b1;
        end
        n_compared++;
        if (!found) begin n_mismatched++; $display("FAIL pause_reach got=%b exp=0100 (timeout)", led); end
        repeat (2) @(negedge sys_clk);
        pause = 1'b1;
        for (int i = 0; i < 10; i++) begin
            @(negedge sys_clk);
            n_compared++;
            if (led !== 4'b0100) begin n_mismatched++; $display("FAIL pause_led i=%0d got=%b exp=0100", i, led); end
            n_compared++;
            if (tick !== 1'b0) begin n_mismatched++; $display("FAIL pause_tick i=%0d got=%b exp=0", i, tick); end
        end
        pause = 1'b0;
        @(negedge sys_clk);
        n_compared++;
        if (tick !== 1'b1) begin n_mismatched++; $display("FAIL resume_tick got=%b exp=1", tick); end
        @(negedge sys_clk);
        n_compared++;
        if (led !== 4'b1000) begin n_mismatched++; $display("FAIL resume_led got=%b exp=1000", led); end
    endtask
`endif

    task automatic test_random();
        for (int i = 0; i < 400; i++) begin
            @(negedge sys_clk);
            n_compared++;
            if (led !== 4'(m_led)) begin n_mismatched++; $display("FAIL rnd_led i=%0d got=%b exp=%b", i, led, 4'(m_led)); end
            n_compared++;
            if (mode !== 2'(m_mode)) begin n_mismatched++; $display("FAIL rnd_mode i=%0d got=%0d exp=%0d", i, mode, m_mode); end
            n_compared++;
            if (tick !== (!sys_rst && m_run && !pz && m_cnt == TB_TICK - 1)) begin
                n_mismatched++; $display("FAIL rnd_tick i=%0d got=%b", i, tick);
            end
            n_compared++;
            if (cmd_ready !== (!sys_rst && !m_load)) begin
                n_mismatched++; $display("FAIL rnd_ready i=%0d got=%b exp=%b", i, cmd_ready, (!sys_rst && !m_load));
            end
            cmd_valid = ($urandom_range(0, 5) == 0);
            cmd_mode  = 2'($urandom_range(0, 3));
            key_pulse = ($urandom_range(0, 7) == 0);
            sys_rst   = ($urandom_range(0, 49) == 0);
`ifdef LED_SCHED_PAUSE_EN
            pause     = ($urandom_range(0, 3) == 0);
`endif
        end
        cmd_valid = 1'b0; key_pulse = 1'b0; sys_rst = 1'b0;
`ifdef LED_SCHED_PAUSE_EN
        pause = 1'b0;
`endif
    endtask

    initial begin
        test_reset();
        test_flow_l();
        test_cmd_key_priority();
        test_back_to_back();
        test_blink_to_off();
        test_reset_in_load();
`ifdef LED_SCHED_PAUSE_EN
        test_pause();
`endif
        test_random();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_compared, n_mismatched);
        $finish;
    end

endmodule

// File: doc/led_pattern_sched.md
LED_PATTERN_SCHED -- requirements
Module: led_pattern_sched

Interface
REQ-001 SHALL have parameter TICK_CYCLES, default 10_000_000, meaning sys_clk cycles per pattern step (0.2 s at 50 MHz); legal range is 2 or more.
REQ-002 SHALL have port sys_clk, input, 1 bit: the single clock; all logic is on its rising edge.
REQ-003 SHALL have port sys_rst, input, 1 bit: reset, synchronous and active-high.
REQ-004 SHALL have port cmd_valid, input, 1 bit: the host requests a mode change.
REQ-005 SHALL have port cmd_mode, input, 2 bits: the requested mode (0 OFF, 1 FLOW_L, 2 FLOW_R, 3 BLINK).
REQ-006 SHALL have port cmd_ready, output, 1 bit: the scheduler can accept a command.
REQ-007 SHALL have port key_pulse, input, 1 bit: a one-cycle, already debounced request to advance to the next mode.
REQ-008 SHALL have port led, output, 4 bits: the LED drive, 1 = lit.
REQ-009 SHALL have port mode, output, 2 bits: the current mode.
REQ-010 SHALL have port tick, output, 1 bit: a one-cycle pulse on each pattern step.

Function
REQ-011 SHALL use a state machine with states S_OFF, S_LOAD and S_RUN.
REQ-012 SHALL drive cmd_ready = !sys_rst && state != S_LOAD.
REQ-013 SHALL accept a command on any edge where cmd_valid && cmd_ready; mode <= cmd_mode and state <= S_LOAD.
REQ-014 SHALL accept key_pulse on any edge where cmd_ready is high and no command is accepted; mode <= mode+1 (wrapping 3->0) and state <= S_LOAD.
REQ-015 SHALL give the command port strict priority; a key_pulse in the same cycle as an accepted command is dropped.
REQ-016 SHALL ignore key_pulse while in S_LOAD.
REQ-017 SHALL hold cmd_valid/cmd_mode to the host until accepted; the scheduler does not buffer commands.
REQ-018 SHALL, in S_LOAD, on the next edge load led with the initial pattern, clear the prescaler and move to S_OFF if mode==0, else to S_RUN.
- Initial patterns: OFF 0000, FLOW_L 0001, FLOW_R 1000, BLINK 1111.
REQ-019 SHALL accept a command equal to the current mode and restart that pattern.
REQ-020 SHALL, in S_RUN, count the prescaler 0..TICK_CYCLES-1 and wrap to 0; tick is 1 only in the cycle where the count equals TICK_CYCLES-1.
REQ-021 SHALL update led on the edge following a cycle with tick high:
- FLOW_L rotates left (0001->0010->0100->1000->0001).
- FLOW_R rotates right.
- BLINK inverts all bits.
REQ-022 SHALL size the prescaler at $clog2(TICK_CYCLES) bits; arithmetic is unsigned.
REQ-023 SHALL keep tick 0 in S_OFF and S_LOAD, with the prescaler held at 0.
REQ-024 SHALL show the new pattern on led two edges after the accepting edge; mode reflects the new value one edge after.

Reset
REQ-025 SHALL, while sys_rst is high at an edge, set state=S_OFF, mode=0, led=0000, prescaler=0 and tick=0.
REQ-026 SHALL treat a reset asserted mid-step or in S_LOAD as overriding; any pending command is discarded.
REQ-027 SHALL hold cmd_ready at 0 while sys_rst is high and return it to 1 on the first cycle after reset releases.

Configuration
REQ-028 SHALL, when macro LED_SCHED_PAUSE_EN is defined, add input pause (1 bit).
- While pause is high in S_RUN, the prescaler holds, tick stays 0 and led is frozen.
- Commands and keys are still accepted.
REQ-029 SHALL, when LED_SCHED_PAUSE_EN is undefined, have no pause port and never pause.

Structure
REQ-030 SHALL place the mode encodings, state encodings and four initial-pattern constants in package led_sched_pkg.
REQ-031 SHALL implement the prescaler and tick generation as sub-module led_tick_gen (ports: clk, rst, clear, enable, tick; parameter TICK_CYCLES).

Verification
REQ-032 SHALL be verified with TICK_CYCLES=4 in simulation, covering the following scenarios.
REQ-033 Reset then cmd_mode=1 accepted -> led=0001 two edges later, then 0010/0100/1000/0001 at 4-cycle spacing, with tick once per step.
REQ-034 cmd_mode=2 and key_pulse in the same cycle -> mode=2 (key dropped), led=1000, then 0100.
REQ-035 In mode 3, key_pulse -> mode=0, led=0000, state S_OFF, tick never pulses; a second key_pulse -> mode=1, led=0001.
REQ-036 cmd_valid held high across S_LOAD -> exactly one accept per cmd_ready-high edge; cmd_ready=0 for exactly one cycle after each accept.
REQ-037 sys_rst asserted in S_LOAD during FLOW_R -> next edge led=0000, mode=0, cmd_ready=0 until release.
REQ-038 With LED_SCHED_PAUSE_EN, pause high for 10 cycles in FLOW_L at led=0100 -> led stays 0100 with no tick, and the step resumes with the preserved prescaler count.
